// File: rtl/pulse_pacer_pkg.sv
// Shared definitions for the pulse_pacer event metering stage.
package pulse_pacer_pkg;

  // Default widths, shared by the top level and any instantiating bench.
  localparam int unsigned COUNT_WIDTH_DEFAULT = 8;
  localparam int unsigned GAP_WIDTH_DEFAULT   = 8;

  // Pacing FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : pulse_pacer_pkg

// File: rtl/pulse_pacer_sat_updown_counter.sv
// Saturating up/down backlog counter with synchronous clear.
// A same-cycle increment and decrement cancel, even at the maximum value.
// drop_c_o flags an increment lost at saturation; count_nxt_c_o exposes the
// value that will be loaded on the coming edge.
module sat_updown_counter #(
  parameter int unsigned pWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              clr_i,
  output logic [pWIDTH-1:0] count_o,
  output logic [pWIDTH-1:0] count_nxt_c_o,
  output logic              drop_c_o
);

  localparam logic [pWIDTH-1:0] CountMax = '1;

  logic [pWIDTH-1:0] count_q;
  logic [pWIDTH-1:0] count_d;
  logic              drop_c;

  // Next count, in priority order: clear, cancel, increment, decrement.
  always_comb begin
    count_d = count_q;
    drop_c  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && dec_i) begin
      count_d = count_q;
    end else if (inc_i) begin
      if (count_q == CountMax) begin
        drop_c = 1'b1;
      end else begin
        count_d = count_q + pWIDTH'(1);
      end
    end else if (dec_i) begin
      if (count_q != '0) begin
        count_d = count_q - pWIDTH'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o       = count_q;
  assign count_nxt_c_o = count_d;
  assign drop_c_o      = drop_c;

endmodule : sat_updown_counter

// File: rtl/pulse_pacer.sv
// Event pacer: counts incoming event strobes and releases them one at a time
// as single-cycle pulses spaced gap_i+2 cycles apart, so the downstream
// handshake synchronizer never sees a pulse while it is still busy.
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int unsigned pCOUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int unsigned pGAP_WIDTH   = GAP_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    event_i,
  input  logic [pGAP_WIDTH-1:0]   gap_i,
  input  logic                    clear_i,
  output logic                    pulse_o,
  output logic [pCOUNT_WIDTH-1:0] pending_o,
  output logic                    overflow_o,
  output logic                    idle_o
);

  state_e                  state_q;
  state_e                  state_d;
  logic [pGAP_WIDTH-1:0]   timer_q;
  logic [pGAP_WIDTH-1:0]   timer_d;
  logic                    pulse_q;
  logic                    pulse_d;
  logic                    idle_q;
  logic                    idle_d;
  logic                    overflow_q;
  logic                    overflow_d;

  logic                    dec_c;
  logic                    drop_c;
  logic                    backlog_c;
  logic [pCOUNT_WIDTH-1:0] count_q;
  logic [pCOUNT_WIDTH-1:0] count_nxt_c;

  // Backlog counter; decremented on the edge that enters FIRE.
  sat_updown_counter #(
    .pWIDTH (pCOUNT_WIDTH)
  ) u_backlog (
    .clk           (clk),
    .reset_n       (reset_n),
    .inc_i         (event_i),
    .dec_i         (dec_c),
    .clr_i         (clear_i),
    .count_o       (count_q),
    .count_nxt_c_o (count_nxt_c),
    .drop_c_o      (drop_c)
  );

  assign backlog_c = (count_q != '0);

  // Next state, hold-off timer and registered output values.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dec_c      = 1'b0;
    pulse_d    = 1'b0;
    idle_d     = 1'b0;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (backlog_c) begin
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          state_d = backlog_c ? ST_FIRE : ST_IDLE;
        end else begin
          timer_d = timer_q - pGAP_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // FIRE entry consumes one event and latches the hold-off length.
    if (state_d == ST_FIRE) begin
      dec_c   = 1'b1;
      timer_d = gap_i;
      pulse_d = 1'b1;
    end

    idle_d = (state_d == ST_IDLE) && (count_nxt_c == '0);

    if (clear_i) begin
      overflow_d = 1'b0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
    end
  end

  // State, timer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pulse_q    <= 1'b0;
      idle_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pulse_q    <= pulse_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
    end
  end

  assign pulse_o    = pulse_q;
  assign pending_o  = count_q;
  assign overflow_o = overflow_q;
  assign idle_o     = idle_q;

endmodule : pulse_pacer

// File: doc/pulse_pacer.md
Name: pulse_pacer

Overview:
- Single-clock event metering stage that sits directly upstream of the handshake pulse synchronizer, driving its source pulse input.
- The synchronizer silently drops source pulses that arrive while a request/acknowledge round trip is in flight.
- This block counts every incoming event pulse and releases them one at a time, with a programmable minimum spacing, so that no event is lost across the clock-domain crossing.
- It also reports backlog depth and a sticky overflow flag.

Parameters:
- pCOUNT_WIDTH, 8: width of the pending-event counter; maximum backlog is 2^pCOUNT_WIDTH-1.
- pGAP_WIDTH, 8: width of the programmable hold-off count.

Ports:
- clk  input  1  block clock; same clock as the downstream synchronizer's source clock.
- reset_n  input  1  asynchronous, active-low reset.
- event_i  input  1  event strobe; each high cycle is one event.
- gap_i  input  pGAP_WIDTH  hold-off cycles after each output pulse; quasi-static.
- clear_i  input  1  synchronous clear of the backlog and the overflow flag.
- pulse_o  output  1  single-cycle pulse to the synchronizer's source pulse input.
- pending_o  output  pCOUNT_WIDTH  current backlog.
- overflow_o  output  1  sticky; at least one event was dropped at saturation.
- idle_o  output  1  high when state is IDLE and the backlog is 0.

Behaviour:
- Reset: asynchronous on reset_n low.
  - All outputs go to 0 and state goes to IDLE; the counter and hold-off timer go to 0.
  - An operation in progress is abandoned; no pulse is emitted after reset deasserts unless new events arrive.
- States: IDLE, FIRE, HOLD. All outputs are registered.
- IDLE:
  - If pending != 0, go to FIRE at the next edge.
  - The counter sampled at that edge is the post-update value, so an event_i in cycle N gives pulse_o high in cycle N+2.
- FIRE:
  - Lasts exactly 1 cycle with pulse_o=1. The counter is decremented on the edge entering FIRE.
  - The hold-off timer is loaded with gap_i on the same edge. Next state is always HOLD.
- HOLD:
  - pulse_o=0 and the timer decrements each cycle.
  - When the timer is 0: go to FIRE if pending != 0, otherwise go to IDLE.
  - gap_i=0 gives a 1-cycle HOLD.
- Spacing:
  - Back-to-back pulse_o rising edges are exactly gap_i+2 cycles apart while a backlog exists.
  - gap_i must cover the synchronizer's busy window; software sets it to at least the worst-case round trip in source clocks.
- gap_i is sampled only on FIRE entry; changes during HOLD take effect at the next FIRE.
- Counter update per edge, in priority order:
  1. clear_i: counter becomes 0 and overflow_o becomes 0; a same-cycle event_i is discarded and a same-cycle decrement is ignored.
  2. Else event_i together with a decrement: counter unchanged.
  3. Else event_i alone: +1, or, if already at max, the counter holds and overflow_o is set.
  4. Else a decrement alone: -1.
- Saturation exception: at max, event_i coinciding with a decrement leaves the counter at max and does not set overflow_o.
- clear_i during FIRE or HOLD does not shorten the pulse or the hold-off. HOLD then exits to IDLE, because the backlog is 0.
- overflow_o, once set, stays high until clear_i or reset.
- pending_o reflects the counter register directly, with no extra latency.

Decomposition:
- Shared include/package holds:
  - state encoding localparams (IDLE=2'd0, FIRE=2'd1, HOLD=2'd2);
  - the pCOUNT_WIDTH and pGAP_WIDTH defaults, so the top level and the testbench agree.
- One natural sub-module: sat_updown_counter. It covers:
  - inputs: inc, dec, clr;
  - outputs: count and a saturation-drop strobe; the parent sets the sticky overflow_o flag from this strobe.
- The FSM and hold-off timer stay in pulse_pacer.

Test Plan:
- Single event: gap_i=4, event_i high in cycle 10 -> pulse_o high only in cycle 12; pending_o 1 in cycle 11, 0 in cycle 12; idle_o high again in cycle 18.
- Burst: gap_i=3, event_i high in cycles 10-14 (5 events) -> exactly 5 pulse_o pulses, in cycles 12, 17, 22, 27, 32; pending_o peaks at 4; overflow_o stays 0.
- Saturation: pCOUNT_WIDTH=3, gap_i=255, 10 consecutive events -> 1 pulse fires, pending_o stops at 7, overflow_o=1 and stays high until clear_i; clear_i then gives pending_o=0 and overflow_o=0.
- Simultaneous event and decrement: backlog 5, event_i high on the FIRE-entry edge -> pending_o stays 5 for that edge; with backlog 7 (max, width 3) -> stays 7 and overflow_o stays 0.
- gap_i=0: 3 events -> pulse_o rising edges exactly 2 cycles apart; a change of gap_i during HOLD from 0 to 9 is applied only after the next FIRE.
- Async reset mid-HOLD with backlog 3: reset_n low for 1 cycle -> all outputs 0 at once; no pulse_o after release; idle_o=1.
